instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and runs a single-outstanding request/ack handshake to instruction memory.
- Buffers one instruction while the pipeline is stalled and applies branch/jump redirects from EX.
- Drives the pc/pc4/instr inputs of the IF/ID register and presents NOP (addi x0,x0,0) whenever no valid instruction is available.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch unit (master) and imem (slave).
// A raised request holds its address until the cycle the ack arrives.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs a single-outstanding imem handshake, holds one instruction
// across pipeline stalls and applies EX redirects, presenting NOP whenever nothing is valid.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       redirect_valid,
   input  logic [31:0]                redirect_pc,
   instr_fetch_unit_if.master         imem,
   output logic [31:0]                pc_out,
   output logic [31:0]                pc4_out,
   output logic [31:0]                instr_out,
   output logic                       fetch_valid
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] drain_addr_q, drain_addr_d;

   logic [31:0] redir_target;
   logic [31:0] pc_plus4;
   logic        unused_redirect_lsbs;

   assign redir_target         = {redirect_pc[31:2], 2'b00};
   assign pc_plus4             = pc_q + 32'd4;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         buf_pc_q     <= '0;
         buf_instr_q  <= NOP_INSTR;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_pc_q     <= buf_pc_d;
         buf_instr_q  <= buf_instr_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      buf_pc_d       = buf_pc_q;
      buf_instr_d    = buf_instr_q;
      drain_addr_d   = drain_addr_q;
      imem.imem_req  = 1'b0;
      imem.imem_addr = pc_q;
      pc_out         = pc_q;
      instr_out      = NOP_INSTR;
      fetch_valid    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (redirect_valid) pc_d = redir_target;
            state_d = REQ;
         end

         REQ: begin
            imem.imem_req  = 1'b1;
            imem.imem_addr = pc_q;
            if (redirect_valid) begin
               // Old request stays on the bus until acked; pc already holds the target.
               pc_d = redir_target;
               if (!imem.imem_ack) begin
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end
            end else if (imem.imem_ack) begin
               pc_out      = pc_q;
               instr_out   = imem.imem_rdata;
               fetch_valid = 1'b1;
               pc_d        = pc_plus4;
               if (stall) begin
                  buf_pc_d    = pc_q;
                  buf_instr_d = imem.imem_rdata;
                  state_d     = FULL;
               end
            end
         end

         FULL: begin
            if (redirect_valid) begin
               pc_d    = redir_target;
               state_d = REQ;
            end else begin
               pc_out      = buf_pc_q;
               instr_out   = buf_instr_q;
               fetch_valid = 1'b1;
               if (!stall) state_d = REQ;
            end
         end

         DRAIN: begin
            imem.imem_req  = 1'b1;
            imem.imem_addr = drain_addr_q;
            if (redirect_valid) pc_d = redir_target;
            if (imem.imem_ack) state_d = REQ;
         end

         default: state_d = IDLE;
      endcase
   end

   assign pc4_out = pc_out + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-programmable imem model
// returning rdata = addr ^ 32'hA5A5_0000.
module tb_instr_fetch_unit;
   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out, pc4_out, instr_out;
   logic        fetch_valid;

   int          errors = 0;
   int          checks = 0;
   int          lat    = 0;
   int          wait_cnt;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   instr_fetch_unit_if imem();

   instr_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (imem.master),
      .pc_out         (pc_out),
      .pc4_out        (pc4_out),
      .instr_out      (instr_out),
      .fetch_valid    (fetch_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory acks once the request has been held for lat cycles.
   assign imem.imem_ack   = imem.imem_req && (wait_cnt >= lat);
   assign imem.imem_rdata = imem.imem_ack ? (imem.imem_addr ^ KEY) : 32'h0;

   always @(posedge clk or negedge reset) begin
      if (!reset)                              wait_cnt <= 0;
      else if (!imem.imem_req || imem.imem_ack) wait_cnt <= 0;
      else                                     wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance to the next negedge, then let combinational outputs settle.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_valid(input string tag, input logic [31:0] pc);
      chk({tag, ".fv"},    {31'b0, fetch_valid}, 32'd1);
      chk({tag, ".pc"},    pc_out,    pc);
      chk({tag, ".pc4"},   pc4_out,   pc + 32'd4);
      chk({tag, ".instr"}, instr_out, pc ^ KEY);
   endtask

   task automatic chk_nop(input string tag);
      chk({tag, ".fv"},    {31'b0, fetch_valid}, 32'd0);
      chk({tag, ".instr"}, instr_out, NOP);
   endtask

   // Reset, release on a negedge, and sit in the IDLE cycle that follows.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      #3;
      chk("rst.req",   {31'b0, imem.imem_req}, 32'd0);
      chk_nop("rst");
      chk("rst.pc",    pc_out,  32'h0);
      chk("rst.pc4",   pc4_out, 32'h4);

      // Zero-wait streaming
      do_reset();
      chk("idle.req", {31'b0, imem.imem_req}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("zw.req", {31'b0, imem.imem_req}, 32'd1);
         chk("zw.addr", imem.imem_addr, 32'(i * 4));
         chk_valid("zw", 32'(i * 4));
      end

      // Three-cycle latency at pc 0x10
      cyc();
      lat = 2; #1;
      chk_nop("lat.w0");
      chk("lat.addr0", imem.imem_addr, 32'h10);
      cyc();
      chk_nop("lat.w1");
      chk("lat.addr1", imem.imem_addr, 32'h10);
      cyc();
      chk_valid("lat.ack", 32'h10);
      cyc();
      lat = 0; #1;
      chk_valid("lat.next", 32'h14);

      // Stall on the ack at pc 8
      do_reset();
      cyc(); cyc();
      cyc();
      stall = 1'b1; #1;
      chk_valid("st.ack", 32'h8);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk_valid("st.full", 32'h8);
         chk("st.req", {31'b0, imem.imem_req}, 32'd0);
      end
      cyc();
      stall = 1'b0; #1;
      chk_valid("st.rel", 32'h8);
      chk("st.relreq", {31'b0, imem.imem_req}, 32'd0);
      cyc();
      chk("st.addr", imem.imem_addr, 32'hC);
      chk_valid("st.after", 32'hC);

      // Redirect while the request to 0x10 is outstanding
      do_reset();
      for (int i = 0; i < 4; i++) cyc();
      cyc();
      lat = 2; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
      chk_nop("dr.redir");
      chk("dr.addr0", imem.imem_addr, 32'h10);
      cyc();
      redirect_valid = 1'b0; #1;
      chk_nop("dr.w1");
      chk("dr.addr1", imem.imem_addr, 32'h10);
      chk("dr.req1", {31'b0, imem.imem_req}, 32'd1);
      cyc();
      chk("dr.ack", {31'b0, imem.imem_ack}, 32'd1);
      chk_nop("dr.drop");
      cyc();
      chk("dr.newaddr", imem.imem_addr, 32'h100);
      lat = 0; #1;
      chk_valid("dr.new", 32'h100);

      // Redirect plus stall on the ack at pc 0x20
      do_reset();
      for (int i = 0; i < 8; i++) cyc();
      cyc();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; #1;
      chk("rs.addr", imem.imem_addr, 32'h20);
      chk_nop("rs.redir");
      cyc();
      stall = 1'b0; redirect_valid = 1'b0; #1;
      chk("rs.newaddr", imem.imem_addr, 32'h40);
      chk_valid("rs.new", 32'h40);

      // Redirect to the top of memory: PC wraps
      cyc();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
      chk_nop("wr.redir");
      cyc();
      redirect_valid = 1'b0; #1;
      chk_valid("wr.top", 32'hFFFF_FFFC);
      chk("wr.pc4", pc4_out, 32'h0);
      cyc();
      chk_valid("wr.zero", 32'h0);

      // Asynchronous reset mid-stream
      cyc();
      chk("ar.pre", {31'b0, imem.imem_req}, 32'd1);
      reset = 1'b0; #1;
      chk("ar.req", {31'b0, imem.imem_req}, 32'd0);
      chk_nop("ar");
      chk("ar.pc", pc_out, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end
endmodule
